// File: rtl/mac_pkg.sv
// Shared Q-format constants, FSM state encoding and Q1.15 saturation helper
// for the biased dot-product sequencer.
package mac_pkg;

    localparam int unsigned Q17_FRAC  = 7;
    localparam int unsigned Q215_FRAC = 14;
    localparam logic [15:0] Q115_MAX  = 16'h7FFF;
    localparam logic [15:0] Q115_MIN  = 16'h8000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        OUT   = 2'd3
    } state_t;

    typedef struct packed {
        logic [15:0] data;
        logic        sat;
    } sat_t;

    // Clip a signed Q.15-aligned value into the 16-bit Q1.15 range.
    function automatic sat_t sat_q115(input logic signed [31:0] v);
        sat_t r;
        r.data = v[15:0];
        r.sat  = 1'b0;
        if (v > 32'sd32767) begin
            r.data = Q115_MAX;
            r.sat  = 1'b1;
        end else if (v < -32'sd32768) begin
            r.data = Q115_MIN;
            r.sat  = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mac_acc_sat.sv
// Datapath for mac_seq: product register, Q2.14 accumulator and the final
// shift/saturate into a registered Q1.15 result.
module mac_acc_sat
    import mac_pkg::*;
#(
    parameter int unsigned ACC_W = 24
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        load,
    input  logic        p_en,
    input  logic        out_en,
    input  logic [7:0]  bias,
    input  logic [7:0]  a_data,
    input  logic [7:0]  b_data,
    output logic [15:0] out_data,
    output logic        out_sat
);

    localparam int unsigned BIAS_SH = Q215_FRAC - Q17_FRAC;

    logic signed [15:0]      prod_q;
    logic                    p_vld;
    logic signed [ACC_W-1:0] acc_q;

    logic signed [15:0] a_ext_c;
    logic signed [15:0] b_ext_c;
    logic signed [15:0] prod_c;
    logic signed [31:0] shifted_c;
    sat_t               sat_c;

    // Sign-extend before multiplying so -1 x -1 lands on +1.0 (0x4000).
    assign a_ext_c   = 16'($signed(a_data));
    assign b_ext_c   = 16'($signed(b_data));
    assign prod_c    = a_ext_c * b_ext_c;
    assign shifted_c = $signed(32'(acc_q)) <<< 1;
    assign sat_c     = sat_q115(shifted_c);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prod_q <= '0;
            p_vld  <= 1'b0;
            acc_q  <= '0;
        end else if (clear) begin
            prod_q <= '0;
            p_vld  <= 1'b0;
        end else if (load) begin
            acc_q  <= ACC_W'($signed(bias)) <<< BIAS_SH;
            p_vld  <= 1'b0;
        end else begin
            if (p_en) begin
                prod_q <= prod_c;
            end
            p_vld <= p_en;
            // Accumulation trails acceptance by one cycle.
            if (p_vld) begin
                acc_q <= acc_q + ACC_W'(prod_q);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data <= '0;
            out_sat  <= 1'b0;
        end else if (out_en) begin
            out_data <= sat_c.data;
            out_sat  <= sat_c.sat;
        end
    end

endmodule

// File: rtl/mac_seq.sv
// Biased dot-product sequencer: accepts len Q1.7 operand pairs, accumulates
// their products onto the bias and returns one saturated Q1.15 result.
module mac_seq
    import mac_pkg::*;
#(
    parameter  int unsigned N_MAX = 64,
    parameter  int unsigned ACC_W = 24,
    localparam int unsigned LEN_W = $clog2(N_MAX + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic [7:0]       bias,
    input  logic             abort,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       a_data,
    input  logic [7:0]       b_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_data,
    output logic             out_sat,
    output logic             busy
);

    state_t           state;
    logic [LEN_W-1:0] cnt;

    logic load_c;
    logic hs_c;
    logic out_en_c;

    // abort outranks every handshake issued in the same cycle.
    assign load_c   = (state == IDLE) && start && !abort;
    assign hs_c     = in_valid && in_ready && !abort;
    assign out_en_c = (state == OUT) && !out_valid && !abort;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else if (abort) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        cnt  <= len;
                        busy <= 1'b1;
                        if (len == '0) begin
                            state <= OUT;
                        end else begin
                            state    <= RUN;
                            in_ready <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (hs_c) begin
                        cnt <= cnt - LEN_W'(1);
                        if (cnt == LEN_W'(1)) begin
                            state    <= DRAIN;
                            in_ready <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    state <= OUT;
                end
                OUT: begin
                    // First OUT cycle registers the result; valid follows.
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    mac_acc_sat #(
        .ACC_W (ACC_W)
    ) u_acc_sat (
        .clk      (clk),
        .rst      (rst),
        .clear    (abort),
        .load     (load_c),
        .p_en     (hs_c),
        .out_en   (out_en_c),
        .bias     (bias),
        .a_data   (a_data),
        .b_data   (b_data),
        .out_data (out_data),
        .out_sat  (out_sat)
    );

endmodule

// File: doc/mac_seq.md
Name: mac_seq

Overview:
Sequencer that computes one biased dot product, y = bias + sum(a[i]*b[i]) for i = 0..len-1, using a single shared Q1.7 x Q1.7 multiply per cycle.
- Operand pairs arrive on a valid/ready stream.
- The saturated Q1.15 result leaves on a valid/ready output.
- Sits between the operand buffers and the activation stage of the inference datapath.

Parameters:
- N_MAX, 64, maximum vector length accepted per job.
- ACC_W, 24, accumulator width in Q(ACC_W-14).14 format; must be >= 16 + clog2(N_MAX+1).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  job start pulse; sampled only in IDLE
- len  in  clog2(N_MAX+1)  vector length; 0..N_MAX
- bias  in  8  Q1.7 bias, captured on start
- abort  in  1  synchronous job cancel
- in_valid  in  1  operand pair valid
- in_ready  out  1  operand pair accepted when in_valid && in_ready
- a_data  in  8  Q1.7 operand A
- b_data  in  8  Q1.7 operand B
- out_valid  out  1  result valid
- out_ready  in  1  result consumed when out_valid && out_ready
- out_data  out  16  Q1.15 saturated result
- out_sat  out  1  result was clipped
- busy  out  1  state != IDLE

Behaviour:
- Reset: clk and reset only; reset is asynchronous, active-high. Asserting rst at any time, including mid-job, forces IDLE. On reset, in_ready=0, out_valid=0, out_data=0, out_sat=0, busy=0, accumulator=0, counter=0, product stage cleared.
- States: IDLE, RUN, DRAIN, OUT.
- IDLE:
  - On start: capture len; load accumulator with sign-extended bias <<< 7 (Q1.7 -> Q2.14 alignment).
  - If len=0, go to OUT (result = bias only); otherwise go to RUN.
  - start while busy is ignored.
- RUN:
  - in_ready=1.
  - Each handshake registers the full-precision signed product a_data*b_data (16-bit Q2.14) into the product stage, sets p_vld, and decrements the counter.
  - Every cycle with p_vld=1 adds the sign-extended product to the accumulator. Accumulation is one cycle behind acceptance.
  - The handshake that takes the last pair moves to DRAIN. in_ready is 0 from that next cycle on.
  - in_valid gaps are allowed; the counter holds while no handshake occurs.
- DRAIN: exactly one cycle; the last product is accumulated; go to OUT.
- OUT:
  - out_valid=1.
  - out_data = accumulator <<< 1, saturated to [0x8000, 0x7FFF]; out_sat=1 iff clipped. Both registered and stable while out_valid=1.
  - On out_ready, go to IDLE next cycle; out_valid falls.
- Arithmetic:
  - Full-precision products: -1 x -1 = +1.0 in Q2.14 (0x4000), never wrapped.
  - No truncation before the final shift.
  - The accumulator cannot overflow inside ACC_W by the parameter rule.
- abort: in any state, returns to IDLE next cycle and clears the product stage and out_valid. A pending result is discarded. abort takes priority over every handshake in the same cycle.
- Latency: last operand handshake to out_valid is 2 cycles. start with len=0 to out_valid is 1 cycle.
- Back-to-back jobs: start is accepted in the first IDLE cycle after the result handshake.

Decomposition:
- Package mac_pkg holds:
  - Q-format constants: Q17_FRAC=7, Q215_FRAC=14, Q115_MAX=16'h7FFF, Q115_MIN=16'h8000.
  - The state enum (IDLE, RUN, DRAIN, OUT).
  - A saturate-to-Q1.15 function.
- One natural sub-module: mac_acc_sat. It holds the product register, the accumulator, and the final shift/saturate, and has clear/load/enable inputs. The FSM and counter stay in mac_seq.

Test Plan:
- bias=0x00, len=2, pairs (0x40,0x40) x2, in_valid continuous -> out_data=0x4000, out_sat=0; out_valid 2 cycles after the 2nd handshake.
- bias=0x20, len=1, pair (0x40,0xE0) -> 0.25 - 0.125: out_data=0x1000, out_sat=0.
- bias=0, len=1, pair (0x80,0x80), i.e. -1 x -1 -> out_data=0x7FFF, out_sat=1. len=2, pairs (0x80,0x7F) x2 -> out_data=0x8000, out_sat=1.
- len=0, bias=0xC0 -> out_valid one cycle after start, out_data=0xC000. Hold out_ready=0 for 5 cycles -> out_data stable; start pulses during that time are ignored.
- len=4 with in_valid toggling every other cycle, plus out_ready delayed 3 cycles -> same result as the continuous run. in_ready=0 after the 4th handshake.
- Abort: abort mid-RUN after 2 of 4 pairs -> busy=0 next cycle, no out_valid. Repeat with rst asserted mid-DRAIN -> all outputs at reset values immediately. A following clean job gives the correct result.
